// File: rtl/axis_pkt_fifo.sv
// Synchronous AXI-Stream FIFO with first-word-fall-through output, optional
// store-and-forward packet mode, fill level, packet count and threshold flags.
module axis_pkt_fifo #(
  parameter int DATA_W      = 32,
  parameter int USER_W      = 8,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0,
  parameter int AF_THRESH   = DEPTH - 2,
  parameter int AE_THRESH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [DATA_W-1:0]          s_tdata,
  input  logic [USER_W-1:0]          s_tuser,
  input  logic                       s_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [DATA_W-1:0]          m_tdata,
  output logic [USER_W-1:0]          m_tuser,
  output logic                       m_tlast,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int EW = DATA_W + USER_W + 1;
  localparam logic [LW-1:0] AF_LVL = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_LVL = LW'(AE_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axis_pkt_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH > DEPTH) begin : g_bad_af
    $error("axis_pkt_fifo: AF_THRESH must not exceed DEPTH");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("axis_pkt_fifo: AE_THRESH must be below DEPTH");
  end

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [EW-1:0] head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign s_tready = !full;
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  // In packet mode the full term lets an oversize packet drain cut-through.
  if (PACKET_MODE != 0) begin : g_pkt_valid
    assign m_tvalid = !empty && ((pkt_count != '0) || full);
  end else begin : g_stream_valid
    assign m_tvalid = !empty;
  end

  assign head = mem[rd_ptr[AW-1:0]];
  assign {m_tlast, m_tuser, m_tdata} = head;

  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

  // Storage write port; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {s_tlast, s_tuser, s_tdata};
    end
  end

  // Pointer, level and packet-count bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      case ({push && s_tlast, pop && m_tlast})
        2'b10:   pkt_count <= pkt_count + LW'(1);
        2'b01:   pkt_count <= pkt_count - LW'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo: one stream-mode and one packet-mode
// instance (DEPTH=16), checked with immediate assertions against bench values.
module tb_axis_pkt_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_s_tvalid, a_s_tready, a_s_tlast, a_m_tvalid, a_m_tready, a_m_tlast;
  logic [31:0] a_s_tdata, a_m_tdata;
  logic [7:0]  a_s_tuser, a_m_tuser;
  logic [4:0]  a_level, a_pkt_count;
  logic        a_af, a_ae;

  logic        b_s_tvalid, b_s_tready, b_s_tlast, b_m_tvalid, b_m_tready, b_m_tlast;
  logic [31:0] b_s_tdata, b_m_tdata;
  logic [7:0]  b_s_tuser, b_m_tuser;
  logic [4:0]  b_level, b_pkt_count;
  logic        b_af, b_ae;

  axis_pkt_fifo #(.DATA_W(32), .USER_W(8), .DEPTH(16), .PACKET_MODE(0)) u_stream (
    .clk(clk), .rst(rst),
    .s_tvalid(a_s_tvalid), .s_tready(a_s_tready), .s_tdata(a_s_tdata),
    .s_tuser(a_s_tuser), .s_tlast(a_s_tlast),
    .m_tvalid(a_m_tvalid), .m_tready(a_m_tready), .m_tdata(a_m_tdata),
    .m_tuser(a_m_tuser), .m_tlast(a_m_tlast),
    .level(a_level), .pkt_count(a_pkt_count),
    .almost_full(a_af), .almost_empty(a_ae)
  );

  axis_pkt_fifo #(.DATA_W(32), .USER_W(8), .DEPTH(16), .PACKET_MODE(1)) u_packet (
    .clk(clk), .rst(rst),
    .s_tvalid(b_s_tvalid), .s_tready(b_s_tready), .s_tdata(b_s_tdata),
    .s_tuser(b_s_tuser), .s_tlast(b_s_tlast),
    .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tdata(b_m_tdata),
    .m_tuser(b_m_tuser), .m_tlast(b_m_tlast),
    .level(b_level), .pkt_count(b_pkt_count),
    .almost_full(b_af), .almost_empty(b_ae)
  );

  int vectors = 0;
  int errors  = 0;

  logic [40:0] q [$];
  int          npkt;
  int          sent;
  int          got;
  logic        pushed;
  logic        popped;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_s_tvalid = 1'b0; a_s_tdata = 32'd0; a_s_tuser = 8'd0; a_s_tlast = 1'b0; a_m_tready = 1'b0;
    b_s_tvalid = 1'b0; b_s_tdata = 32'd0; b_s_tuser = 8'd0; b_s_tlast = 1'b0; b_m_tready = 1'b0;
    npkt = 0; sent = 0; got = 0; pushed = 1'b0; popped = 1'b0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_a_tready", 64'(a_s_tready), 64'd1);
    chk("rst_a_tvalid", 64'(a_m_tvalid), 64'd0);
    chk("rst_a_ae",     64'(a_ae),       64'd1);
    chk("rst_a_af",     64'(a_af),       64'd0);
    chk("rst_a_level",  64'(a_level),    64'd0);
    chk("rst_b_tready", 64'(b_s_tready), 64'd1);
    chk("rst_b_tvalid", 64'(b_m_tvalid), 64'd0);
    chk("rst_b_pkt",    64'(b_pkt_count), 64'd0);

    // Fill stream FIFO to full with consumer stalled
    a_m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_s_tvalid = 1'b1; a_s_tdata = 32'(i); a_s_tuser = 8'(i); a_s_tlast = (i == 15);
      tick();
      chk("fill_level", 64'(a_level),   64'(i + 1));
      chk("fill_af",    64'(a_af),      64'((i + 1) >= 14));
      chk("fill_head",  64'(a_m_tdata), 64'd0);
    end
    chk("full_tready", 64'(a_s_tready), 64'd0);
    chk("full_tvalid", 64'(a_m_tvalid), 64'd1);
    a_s_tdata = 32'd99; a_s_tlast = 1'b0;
    tick();
    chk("full_ignore_level", 64'(a_level),   64'd16);
    chk("full_hold_head",    64'(a_m_tdata), 64'd0);

    // Drain in order
    a_s_tvalid = 1'b0; a_m_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_level", 64'(a_level),   64'(16 - i));
      chk("drain_ae",    64'(a_ae),      64'((16 - i) <= 2));
      chk("drain_data",  64'(a_m_tdata), 64'(i));
      chk("drain_user",  64'(a_m_tuser), 64'(i));
      chk("drain_last",  64'(a_m_tlast), 64'(i == 15));
      tick();
    end
    chk("drained_level",  64'(a_level),    64'd0);
    chk("drained_ae",     64'(a_ae),       64'd1);
    chk("drained_tvalid", 64'(a_m_tvalid), 64'd0);

    // Simultaneous push+pop at level 8 across several pointer wraps
    a_m_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_s_tvalid = 1'b1; a_s_tdata = 32'(i); a_s_tlast = 1'b0;
      tick();
    end
    a_m_tready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      a_s_tdata = 32'(8 + k);
      chk("steady_level", 64'(a_level),   64'd8);
      chk("steady_data",  64'(a_m_tdata), 64'(k));
      tick();
    end
    a_s_tvalid = 1'b0;
    for (int k = 100; k < 108; k++) begin
      chk("steady_tail", 64'(a_m_tdata), 64'(k));
      tick();
    end
    chk("steady_empty", 64'(a_level), 64'd0);

    // Packet mode: 3-word packet held until its tlast word lands
    b_m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_s_tvalid = 1'b1; b_s_tdata = 32'(32'hA0 + i); b_s_tuser = 8'h5A; b_s_tlast = (i == 2);
      tick();
      chk("pkt_tvalid", 64'(b_m_tvalid),  64'(i == 2));
      chk("pkt_count",  64'(b_pkt_count), 64'(i == 2));
    end
    b_s_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("pkt_data", 64'(b_m_tdata), 64'(32'hA0 + i));
      chk("pkt_last", 64'(b_m_tlast), 64'(i == 2));
      tick();
    end
    chk("pkt_count_end", 64'(b_pkt_count), 64'd0);
    chk("pkt_level_end", 64'(b_level),     64'd0);
    chk("pkt_tvalid_end", 64'(b_m_tvalid), 64'd0);

    // Packet mode: 20-word packet escapes through the full condition
    for (int i = 0; i < 16; i++) begin
      b_s_tvalid = 1'b1; b_s_tdata = 32'(32'h100 + i); b_s_tlast = 1'b0;
      tick();
      chk("big_tvalid", 64'(b_m_tvalid), 64'(i == 15));
    end
    chk("big_level",  64'(b_level),    64'd16);
    chk("big_tready", 64'(b_s_tready), 64'd0);
    sent = 16; got = 0;
    for (int c = 0; c < 200 && got < 20; c++) begin
      b_s_tvalid = (sent < 20);
      b_s_tdata  = 32'(32'h100 + sent);
      b_s_tlast  = (sent == 19);
      pushed = b_s_tvalid && b_s_tready;
      popped = b_m_tvalid;
      if (popped) begin
        chk("big_data", 64'(b_m_tdata), 64'(32'h100 + got));
        chk("big_last", 64'(b_m_tlast), 64'(got == 19));
      end
      tick();
      if (pushed) sent++;
      if (popped) got++;
    end
    b_s_tvalid = 1'b0;
    chk("big_delivered", 64'(got),         64'd20);
    chk("big_level_end", 64'(b_level),     64'd0);
    chk("big_pkt_end",   64'(b_pkt_count), 64'd0);

    // Random traffic on the stream FIFO against a queue model
    a_s_tuser = 8'hAA;
    npkt = 0;
    for (int c = 0; c < 5000; c++) begin
      chk("rnd_level",  64'(a_level),     64'(q.size()));
      chk("rnd_tready", 64'(a_s_tready),  64'(q.size() != 16));
      chk("rnd_tvalid", 64'(a_m_tvalid),  64'(q.size() != 0));
      chk("rnd_pkt",    64'(a_pkt_count), 64'(npkt));
      if (q.size() != 0) begin
        chk("rnd_data", 64'(a_m_tdata), 64'(q[0][31:0]));
        chk("rnd_user", 64'(a_m_tuser), 64'(q[0][39:32]));
        chk("rnd_last", 64'(a_m_tlast), 64'(q[0][40]));
      end
      a_s_tvalid = 1'($urandom_range(0, 1));
      a_s_tdata  = $urandom;
      a_s_tlast  = 1'($urandom_range(0, 1));
      a_m_tready = 1'($urandom_range(0, 1));
      pushed = a_s_tvalid && (q.size() < 16);
      popped = a_m_tready && (q.size() != 0);
      tick();
      if (popped) begin
        if (q[0][40]) npkt--;
        void'(q.pop_front());
      end
      if (pushed) begin
        q.push_back({a_s_tlast, a_s_tuser, a_s_tdata});
        if (a_s_tlast) npkt++;
      end
    end
    a_s_tvalid = 1'b0; a_m_tready = 1'b1;
    repeat (17) tick();
    chk("rnd_drained", 64'(a_level), 64'd0);

    // Reset mid-packet discards everything, then a fresh packet passes
    b_m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_s_tvalid = 1'b1; b_s_tdata = 32'(32'hB0 + i); b_s_tlast = (i == 1);
      tick();
    end
    b_s_tvalid = 1'b0;
    chk("prerst_level", 64'(b_level),     64'd5);
    chk("prerst_pkt",   64'(b_pkt_count), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_level",  64'(b_level),     64'd0);
    chk("midrst_pkt",    64'(b_pkt_count), 64'd0);
    chk("midrst_tvalid", 64'(b_m_tvalid),  64'd0);
    chk("midrst_tready", 64'(b_s_tready),  64'd1);
    for (int i = 0; i < 2; i++) begin
      b_s_tvalid = 1'b1; b_s_tdata = 32'(32'hC0 + i); b_s_tlast = (i == 1);
      tick();
    end
    b_s_tvalid = 1'b0;
    chk("fresh_tvalid", 64'(b_m_tvalid),  64'd1);
    chk("fresh_pkt",    64'(b_pkt_count), 64'd1);
    b_m_tready = 1'b1;
    chk("fresh_data0", 64'(b_m_tdata), 64'h0C0);
    chk("fresh_last0", 64'(b_m_tlast), 64'd0);
    tick();
    chk("fresh_data1", 64'(b_m_tdata), 64'h0C1);
    chk("fresh_last1", 64'(b_m_tlast), 64'd1);
    tick();
    chk("fresh_level", 64'(b_level), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
Parametrised synchronous AXI-Stream FIFO, the successor to the basic stream FIFO in the DAQ datapath. It carries tdata/tuser/tlast from a producer (e.g. the channel packer) to a consumer (e.g. the DMA/uplink framer). It adds:
- Selectable store-and-forward packet mode.
- A fill-level output.
- Programmable almost-full/almost-empty flags.
- A stored-packet count.

Parameters:
DATA_W, 32, tdata width in bits (>=1)
USER_W, 8, tuser width in bits (>=1)
DEPTH, 16, storage depth in words; power of two, >=2
PACKET_MODE, 0, 0 = cut-through stream FIFO; 1 = store-and-forward on tlast
AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
s_tvalid  in  1  input beat valid
s_tready  out  1  input beat ready
s_tdata  in  DATA_W  input data
s_tuser  in  USER_W  input sideband
s_tlast  in  1  input end-of-packet
m_tvalid  out  1  output beat valid
m_tready  in  1  output beat ready
m_tdata  out  DATA_W  output data
m_tuser  out  USER_W  output sideband
m_tlast  out  1  output end-of-packet
level  out  $clog2(DEPTH+1)  words stored, 0..DEPTH
pkt_count  out  $clog2(DEPTH+1)  complete packets (tlast words) stored
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH

Behaviour:
- Storage and pointers:
  - Storage is a DEPTH x (DATA_W+USER_W+1) array.
  - Write and read pointers are $clog2(DEPTH) bits plus one wrap bit.
  - full = pointers equal except for the wrap bit; empty = pointers fully equal.
- Push and pop:
  - push = s_tvalid && s_tready; pop = m_tvalid && m_tready.
  - s_tready = !full, combinational from registered state.
  - There is no full-bypass. When full, s_tready=0 even if a pop occurs in the same cycle.
- Output path:
  - First-word-fall-through: m_tdata/m_tuser/m_tlast = entry at the read pointer.
  - Output fields are don't-care while m_tvalid=0.
- m_tvalid rule:
  - PACKET_MODE=0: m_tvalid = !empty.
  - PACKET_MODE=1: m_tvalid = !empty && (pkt_count>0 || full).
  - The "full" term is an oversize-packet escape. A packet longer than DEPTH drains cut-through instead of deadlocking.
- Latency: a word pushed at edge N is visible on m_* after edge N.
  - PACKET_MODE=0: m_tvalid can be 1 in the cycle after edge N.
  - PACKET_MODE=1: m_tvalid waits until the packet's tlast word is pushed.
- Stability: while m_tvalid && !m_tready, m_tdata/m_tuser/m_tlast are held stable. Nothing else changes the read pointer.
- level: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop. It is registered.
- pkt_count:
  - +1 on a push with s_tlast=1.
  - -1 on a pop with m_tlast=1.
  - Unchanged if both occur in the same cycle.
- Flags: almost_full and almost_empty are derived combinationally from registered level.
- Wrap-around: pointers wrap modulo DEPTH; the wrap bit toggles. There is no data or flag glitch at wrap.
- Reset:
  - rst=1 at an edge clears both pointers, level=0 and pkt_count=0.
  - After reset: s_tready=1, m_tvalid=0, almost_empty=1, almost_full=0 (for AF_THRESH>0).
  - Storage contents are not reset.
  - Reset mid-packet discards all stored words, including partial packets. There is no recovery of in-flight data.
- Error handling:
  - No overflow or underflow is possible by construction.
  - Push while s_tready=0 and pop while m_tvalid=0 are ignored.
- Parameter checks (elaboration assertions):
  - DEPTH is a power of two.
  - AF_THRESH <= DEPTH.
  - AE_THRESH < DEPTH.

Test Plan:
1. PACKET_MODE=0, DEPTH=16, m_tready=0. Push 16 words 0..15 → s_tready=0 after the 16th push; level=16; almost_full=1; m_tdata=0 held stable. Then m_tready=1 → words 0..15 exit in order, level returns to 0, almost_empty=1.
2. PACKET_MODE=1. Push 3-word packet (tlast on word 2) with m_tready=1 → m_tvalid stays 0 until the edge after the tlast push. pkt_count=1. Packet drains in 3 cycles; pkt_count returns to 0.
3. PACKET_MODE=1, DEPTH=16. Push a 20-word packet with m_tready=1 → at level=16 m_tvalid asserts via the full escape. All 20 words are delivered in order with tlast on word 19; no deadlock.
4. Simultaneous push+pop at level=8 for 100 cycles, data incrementing → level stays 8; pointers wrap multiple times; data is in order with no loss.
5. Random s_tvalid/m_tready at 50% each for 5000 cycles, tuser=8'hAA, random tlast → scoreboard matches every tdata/tuser/tlast. No tdata change under backpressure. level equals the scoreboard size every cycle.
6. Assert rst for 1 cycle at level=5, pkt_count=1, mid-packet → next cycle level=0, pkt_count=0, m_tvalid=0, s_tready=1. A fresh packet afterwards passes correctly.
